// File: rtl/unet_pkg.sv
// Shared definitions for the U-Net host responder.
// Ctrl codes, responder FSM states and err bit positions.
package unet_pkg;

  localparam logic [2:0] CALCULATING  = 3'd0;
  localparam logic [2:0] SEND_WEIGHTS = 3'd1;
  localparam logic [2:0] SEND_DATA    = 3'd2;
  localparam logic [2:0] DATA_READY   = 3'd3;
  localparam logic [2:0] SAY_IDLE     = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KICK   = 3'd1,
    S_WAIT   = 3'd2,
    S_SERVE  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam int ERR_TO  = 0;
  localparam int ERR_OVR = 1;
  localparam int ERR_ILL = 2;

endpackage

// File: rtl/unet_stream_reader.sv
// Streams words from a 1-cycle-latency memory to the accelerator.
// Ports: clr/req in; addr to memory; rdata from memory;
// wdata/wvalid two cycles after req; ovf flags a request past the end.
module unet_stream_reader #(
  parameter int DATA_W = 32,
  parameter int AW     = 16,
  parameter int NUM    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req,
  output logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  output logic              ovf
);

  localparam logic [AW:0] LIM = (AW+1)'(NUM);

  logic [AW:0] ptr;
  logic        full;
  logic        v1;
  logic        o1;

  // One spare pointer bit so saturation at NUM never wraps.
  assign full = (ptr == LIM);
  assign ovf  = req && full;
  assign addr = ptr[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      v1     <= 1'b0;
      o1     <= 1'b0;
      wvalid <= 1'b0;
      wdata  <= '0;
    end else begin
      if (clr) begin
        ptr <= '0;
      end else if (req && !full) begin
        ptr <= ptr + 1'b1;
      end
      // Stage 1 tracks the memory read; stage 2 drives the port.
      v1     <= req;
      o1     <= req && full;
      wvalid <= v1;
      wdata  <= (v1 && !o1) ? rdata : '0;
    end
  end

endmodule

// File: rtl/unet_host_responder.sv
// Host-side responder driving the U-Net accelerator ctrl protocol.
// Ports: start/busy/done/err to host; enpulse/ctrl/busy/data to
// accelerator; w_*, d_* read ports; r_* result write port;
// checksum is live only with UNET_RESP_CHECKSUM_EN defined.
module unet_host_responder
  import unet_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int AW          = 16,
  parameter int NUM_WEIGHTS = 4096,
  parameter int NUM_DATA    = 4096,
  parameter int NUM_RESULTS = 4096,
  parameter int START_TO    = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              unet_enpulse,
  input  logic [2:0]        acc_ctrl,
  input  logic              acc_busy,
  output logic [DATA_W-1:0] acc_wdata,
  output logic              acc_wvalid,
  input  logic [DATA_W-1:0] acc_rdata,
  output logic [AW-1:0]     w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic [AW-1:0]     d_addr,
  input  logic [DATA_W-1:0] d_rdata,
  output logic [AW-1:0]     r_addr,
  output logic [DATA_W-1:0] r_wdata,
  output logic              r_we,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err,
  output logic [DATA_W-1:0] checksum
);

  localparam int CW = $clog2(START_TO + 1);
  localparam logic [AW:0] RLIM = (AW+1)'(NUM_RESULTS);

  state_t state;
  state_t nxt;

  logic [CW-1:0]     cnt;
  logic [AW:0]       rptr;
  logic              kick_go;
  logic              serve;
  logic              w_req;
  logic              d_req;
  logic              r_req;
  logic              r_full;
  logic              r_ovf;
  logic              illegal;
  logic              timeout;
  logic              w_ovf;
  logic              d_ovf;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] d_wdata;
  logic              w_wvalid;
  logic              d_wvalid;

  assign kick_go = (state == S_IDLE) && start;
  // Gate dispatch with rst so nothing is touched in a reset cycle.
  assign serve   = (state == S_SERVE) && !rst;
  assign w_req   = serve && (acc_ctrl == SEND_WEIGHTS);
  assign d_req   = serve && (acc_ctrl == SEND_DATA);
  assign r_req   = serve && (acc_ctrl == DATA_READY);
  assign illegal = serve && (acc_ctrl > SAY_IDLE);
  assign timeout = (state == S_WAIT) && !acc_busy
                && (cnt == CW'(START_TO - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (start) nxt = S_KICK;
      S_KICK:   nxt = S_WAIT;
      S_WAIT: begin
        if (acc_busy) begin
          nxt = S_SERVE;
        end else if (timeout) begin
          nxt = S_FINISH;
        end
      end
      S_SERVE: begin
        if (acc_ctrl == SAY_IDLE || !acc_busy) begin
          nxt = S_FINISH;
        end
      end
      S_FINISH: nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  assign unet_enpulse = (state == S_KICK);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_FINISH);

  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || kick_go) begin
      err <= '0;
    end else begin
      if (timeout)                 err[ERR_TO]  <= 1'b1;
      if (w_ovf || d_ovf || r_ovf) err[ERR_OVR] <= 1'b1;
      if (illegal)                 err[ERR_ILL] <= 1'b1;
    end
  end

  assign r_full  = (rptr == RLIM);
  assign r_ovf   = r_req && r_full;
  assign r_we    = r_req && !r_full;
  assign r_addr  = rptr[AW-1:0];
  assign r_wdata = r_req ? acc_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst || kick_go) begin
      rptr <= '0;
    end else if (r_we) begin
      rptr <= rptr + 1'b1;
    end
  end

  unet_stream_reader #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .NUM    (NUM_WEIGHTS)
  ) u_wrd (
    .clk    (clk),
    .rst    (rst),
    .clr    (kick_go),
    .req    (w_req),
    .addr   (w_addr),
    .rdata  (w_rdata),
    .wdata  (w_wdata),
    .wvalid (w_wvalid),
    .ovf    (w_ovf)
  );

  unet_stream_reader #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .NUM    (NUM_DATA)
  ) u_drd (
    .clk    (clk),
    .rst    (rst),
    .clr    (kick_go),
    .req    (d_req),
    .addr   (d_addr),
    .rdata  (d_rdata),
    .wdata  (d_wdata),
    .wvalid (d_wvalid),
    .ovf    (d_ovf)
  );

  // Each reader zeroes its word when idle, so OR merges cleanly.
  assign acc_wdata  = w_wdata | d_wdata;
  assign acc_wvalid = w_wvalid | d_wvalid;

`ifdef UNET_RESP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  always_ff @(posedge clk) begin
    if (rst || kick_go) begin
      sum <= '0;
    end else if (r_we) begin
      sum <= sum + r_wdata;
    end
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_unet_host_responder.sv
// Directed bench for unet_host_responder with a cycle schedule
// model for the word streams, result writes and checksum.
module tb_unet_host_responder;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NW = 4096;
  localparam int ND = 2;
  localparam int NR = 4096;
  localparam int NC = 2048;

`ifdef UNET_RESP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          unet_enpulse;
  logic [2:0]    acc_ctrl;
  logic          acc_busy;
  logic [DW-1:0] acc_wdata;
  logic          acc_wvalid;
  logic [DW-1:0] acc_rdata;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_rdata;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic          busy;
  logic          done;
  logic [2:0]    err;
  logic [DW-1:0] checksum;

  always #5 clk = ~clk;

  unet_host_responder #(
    .DATA_W      (DW),
    .AW          (AW),
    .NUM_WEIGHTS (NW),
    .NUM_DATA    (ND),
    .NUM_RESULTS (NR),
    .START_TO    (256)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .unet_enpulse (unet_enpulse),
    .acc_ctrl     (acc_ctrl),
    .acc_busy     (acc_busy),
    .acc_wdata    (acc_wdata),
    .acc_wvalid   (acc_wvalid),
    .acc_rdata    (acc_rdata),
    .w_addr       (w_addr),
    .w_rdata      (w_rdata),
    .d_addr       (d_addr),
    .d_rdata      (d_rdata),
    .r_addr       (r_addr),
    .r_wdata      (r_wdata),
    .r_we         (r_we),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .checksum     (checksum)
  );

  logic [DW-1:0] wmem [0:NW-1];
  logic [DW-1:0] dmem [0:3];
  logic [DW-1:0] rmem [0:15];

  always @(posedge clk) begin
    w_rdata <= wmem[w_addr];
    d_rdata <= dmem[d_addr[1:0]];
    if (r_we) rmem[r_addr[3:0]] <= r_wdata;
  end

  int nt = 0;
  int nf = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nt++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model state: owned by the compare process only.
  bit            ev [0:NC-1];
  logic [DW-1:0] ed [0:NC-1];
  int            mw = 0;
  int            md = 0;
  int            mr = 0;
  logic [DW-1:0] msum = '0;
  int            seen_id = 0;
  logic [DW-1:0] wlog [$];
  int            npulse = 0;
  int            ndone = 0;

  // Written by stimulus only.
  bit chk_en = 1'b0;
  bit m_serve = 1'b0;
  int run_id = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (acc_wvalid) wlog.push_back(acc_wdata);
    if (unet_enpulse) npulse++;
    if (done) ndone++;
    if (chk_en && cyc + 2 < NC) begin
      if (run_id != seen_id) begin
        seen_id = run_id;
        mw = 0;
        md = 0;
        mr = 0;
        msum = '0;
      end
      chk("wvalid", 32'(acc_wvalid), 32'(ev[cyc]));
      chk("wdata", acc_wdata, ed[cyc]);
      chk("checksum", checksum, CK ? msum : 32'h0);
      if (!rst && m_serve && acc_ctrl == 3'd3 && mr < NR) begin
        chk("r_we", 32'(r_we), 32'd1);
        chk("r_addr", 32'(r_addr), 32'(mr));
        chk("r_wdata", r_wdata, acc_rdata);
        msum = msum + acc_rdata;
        mr++;
      end else begin
        chk("r_we_idle", 32'(r_we), 32'd0);
      end
      if (rst) begin
        for (int k = 1; k <= 2; k++) begin
          ev[cyc+k] = 1'b0;
          ed[cyc+k] = '0;
        end
        mw = 0;
        md = 0;
        mr = 0;
        msum = '0;
      end else if (m_serve) begin
        if (acc_ctrl == 3'd1) begin
          ev[cyc+2] = 1'b1;
          ed[cyc+2] = (mw < NW) ? wmem[mw] : 32'h0;
          if (mw < NW) mw++;
        end
        if (acc_ctrl == 3'd2) begin
          ev[cyc+2] = 1'b1;
          ed[cyc+2] = (md < ND) ? dmem[md] : 32'h0;
          if (md < ND) md++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input bit with_busy);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_id++;
    chk("kick_pulse", 32'(unet_enpulse), 32'd1);
    chk("kick_busy", 32'(busy), 32'd1);
    if (with_busy) begin
      tick();
      chk("pulse_1cyc", 32'(unet_enpulse), 32'd0);
      tick();
      tick();
      acc_busy = 1'b1;
      tick();
      m_serve = 1'b1;
    end
  endtask

  task automatic phase(input logic [2:0] c, input int n,
                       input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      acc_ctrl = c;
      acc_rdata = base + 32'(i);
      tick();
    end
    acc_ctrl = 3'd0;
    acc_rdata = '0;
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_pulse"}, 32'(unet_enpulse), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_err"}, 32'(err), 32'd0);
    chk({nm, "_wv"}, 32'(acc_wvalid), 32'd0);
    chk({nm, "_wd"}, acc_wdata, 32'd0);
    chk({nm, "_rwe"}, 32'(r_we), 32'd0);
    chk({nm, "_rwd"}, r_wdata, 32'd0);
    chk({nm, "_radr"}, 32'(r_addr), 32'd0);
    chk({nm, "_wadr"}, 32'(w_addr), 32'd0);
    chk({nm, "_dadr"}, 32'(d_addr), 32'd0);
    chk({nm, "_ck"}, checksum, 32'd0);
  endtask

  int p0;
  int d0;
  int n;

  initial begin
    for (int i = 0; i < NW; i++) wmem[i] = 32'h1000 + 32'(i);
    for (int i = 0; i < 4; i++) dmem[i] = 32'h2000 + 32'(i);
    for (int i = 0; i < 16; i++) rmem[i] = '0;
    rst = 1'b1;
    start = 1'b0;
    acc_ctrl = 3'd0;
    acc_busy = 1'b0;
    acc_rdata = '0;
    tick();
    tick();
    tick();
    all_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    p0 = npulse;
    launch(1'b1);
    chk("one_pulse", 32'(npulse - p0), 32'd1);
    chk("serve_busy", 32'(busy), 32'd1);

    phase(3'd1, 4, 0);
    phase(3'd0, 4, 0);
    chk("wlog_n4", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("w_word", wlog[i], 32'h1000 + 32'(i));

    phase(3'd1, 2, 0);
    phase(3'd0, 4, 0);
    chk("wlog_n6", 32'(wlog.size()), 32'd6);
    chk("w_word4", wlog[4], 32'h1004);
    chk("w_word5", wlog[5], 32'h1005);

    phase(3'd3, 3, 7);
    tick();
    chk("res0", rmem[0], 32'd7);
    chk("res1", rmem[1], 32'd8);
    chk("res2", rmem[2], 32'd9);
    chk("ck_lit", checksum, CK ? 32'd24 : 32'd0);
    chk("err_none", 32'(err), 32'd0);

    phase(3'd2, 3, 0);
    phase(3'd0, 4, 0);
    chk("wlog_n9", 32'(wlog.size()), 32'd9);
    chk("d_word0", wlog[6], 32'h2000);
    chk("d_word1", wlog[7], 32'h2001);
    chk("d_ovr", wlog[8], 32'h0);
    chk("err_ovr", 32'(err), 32'b010);

    phase(3'd6, 1, 0);
    chk("err_ill", 32'(err), 32'b110);

    d0 = ndone;
    acc_ctrl = 3'd4;
    tick();
    m_serve = 1'b0;
    acc_ctrl = 3'd0;
    acc_busy = 1'b0;
    chk("done_hi", 32'(done), 32'd1);
    tick();
    chk("done_lo", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("err_sticky", 32'(err), 32'b110);
    chk("done_once", 32'(ndone - d0), 32'd1);

    d0 = ndone;
    launch(1'b0);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'd257);
    chk("err_to", 32'(err), 32'b001);
    tick();
    chk("to_done_lo", 32'(done), 32'd0);
    chk("to_done_once", 32'(ndone - d0), 32'd1);

    launch(1'b1);
    chk("err_cleared", 32'(err), 32'd0);
    acc_ctrl = 3'd2;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc_ctrl = 3'd0;
    acc_busy = 1'b0;
    m_serve = 1'b0;
    all_zero("rst_mid");
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule

// File: doc/unet_host_responder.md
Name: unet_host_responder

Overview:
- Host-side responder for the U-Net accelerator FSM control interface.
- Launches a run with a one-cycle `unet_enpulse`, then watches the accelerator's 3-bit `ctrl` code:
  - streams weight words from weight memory on SEND_WEIGHTS;
  - streams input words from data memory on SEND_DATA;
  - writes result words to result memory on DATA_READY;
  - finishes when the accelerator reports SAY_IDLE.
- Sits between the system memories and the accelerator top.

Parameters:
- DATA_W, 32: word width of all data paths.
- AW, 16: address width of weight, data and result memories.
- NUM_WEIGHTS, 4096: weight words available; valid addresses 0..NUM_WEIGHTS-1.
- NUM_DATA, 4096: input words available.
- NUM_RESULTS, 4096: result slots available.
- START_TO, 256: cycles allowed between `unet_enpulse` and `acc_busy`=1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  run request pulse; ignored unless idle
- unet_enpulse  out  1  one-cycle launch pulse to accelerator
- acc_ctrl  in  3  accelerator ctrl code
- acc_busy  in  1  accelerator busy flag
- acc_wdata  out  DATA_W  word to accelerator data_in
- acc_wvalid  out  1  acc_wdata holds a fresh word this cycle
- acc_rdata  in  DATA_W  accelerator data_out
- w_addr  out  AW  weight memory address; synchronous read, 1-cycle latency
- w_rdata  in  DATA_W  weight memory read data
- d_addr  out  AW  data memory address; same timing as weight memory
- d_rdata  in  DATA_W  data memory read data
- r_addr  out  AW  result memory address
- r_wdata  out  DATA_W  result write data
- r_we  out  1  result write enable
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- err  out  3  sticky: [0] start timeout, [1] pointer overrun, [2] illegal ctrl code
- checksum  out  DATA_W  result checksum (see Optional Feature)

Behaviour:
- Clock and reset:
  - Single clock `clk`. Reset `rst` is synchronous and active-high.
  - On reset, all outputs are 0, all pointers are 0, and the FSM is in IDLE.
  - Reset mid-run aborts immediately; no memory write occurs in the reset cycle.
- Ctrl codes: CALCULATING=0, SEND_WEIGHTS=1, SEND_DATA=2, DATA_READY=3, SAY_IDLE=4. Codes 5..7 are illegal.
- FSM states: IDLE, KICK, WAIT_BUSY, SERVE, FINISH.
  - IDLE:
    - `start`=1 → KICK. Entering KICK clears `err`, all pointers and `checksum`.
    - `start`=0 → stay in IDLE.
  - KICK: `unet_enpulse`=1 for exactly this cycle, then WAIT_BUSY.
  - WAIT_BUSY:
    - `acc_busy`=1 → SERVE.
    - START_TO cycles elapse without `acc_busy` → set err[0], go to FINISH.
  - SERVE: dispatch each cycle on the sampled `acc_ctrl`.
    - Leave for FINISH when `acc_ctrl`=SAY_IDLE, or when `acc_busy`=0.
  - FINISH: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- Weight stream (inside SERVE):
  - While `acc_ctrl`=SEND_WEIGHTS, each cycle drives `w_addr`=wptr and increments wptr.
  - The read word appears on `acc_wdata` with `acc_wvalid`=1 two cycles after its address cycle.
  - If the first sampled SEND_WEIGHTS cycle is t0, word k is valid at t0+2+k.
  - When ctrl leaves SEND_WEIGHTS, words already in flight (up to 2) are still delivered, then `acc_wvalid`=0.
- Data stream: identical to the weight stream, using dptr, `d_addr`, `d_rdata`, SEND_DATA.
- Pointer persistence: wptr and dptr persist across phases, so later layers continue from where the previous phase stopped.
- Result capture:
  - While `acc_ctrl`=DATA_READY: `r_we`=1, `r_wdata`=`acc_rdata`, `r_addr`=rptr in the same cycle; rptr increments.
  - Same-cycle capture, no latency.
- Overrun:
  - Triggered when wptr=NUM_WEIGHTS, dptr=NUM_DATA, or rptr=NUM_RESULTS and another access is requested.
  - Response: pointer saturates, `acc_wdata`=0 with `acc_wvalid`=1, or `r_we` is suppressed; err[1] is set; the run continues.
- Other ctrl codes:
  - CALCULATING: `acc_wdata`=0, `acc_wvalid`=0, no memory accesses.
  - Illegal code: set err[2], treat as CALCULATING.
- `start` outside IDLE is ignored.
- `acc_wdata` is registered. Whenever `acc_wvalid`=0, `acc_wdata` is 0.

Optional Feature:
- Macro: UNET_RESP_CHECKSUM_EN.
- Defined:
  - `checksum` = running 32-bit wrap-around sum of every `r_wdata` written with `r_we`=1.
  - Cleared on entering KICK; held after `done`.
- Undefined: `checksum` is tied to 0 and no adder is built.

Decomposition:
- Package `unet_pkg`:
  - ctrl code localparams: CALCULATING, SEND_WEIGHTS, SEND_DATA, DATA_READY, SAY_IDLE;
  - FSM state encodings;
  - err bit indices.
- Sub-module `unet_stream_reader`:
  - one instance each for the weights and data streams;
  - contains the pointer, saturation logic and the 2-stage valid pipeline.

Test Plan:
- start pulse, `acc_busy` rises 3 cycles after `unet_enpulse` → `unet_enpulse` high exactly 1 cycle; `busy`=1; state SERVE.
- ctrl=SEND_WEIGHTS for 4 cycles from t0, weight mem[i]=0x1000+i → `acc_wdata` = 0x1000..0x1003 at t0+2..t0+5 with `acc_wvalid`=1; then `acc_wvalid`=0.
- Second SEND_WEIGHTS phase of 2 cycles → words 0x1004 and 0x1005 delivered (pointer persisted).
- ctrl=DATA_READY for 3 cycles, `acc_rdata`=7,8,9 → result writes at addresses 0,1,2; with UNET_RESP_CHECKSUM_EN, `checksum`=24.
- `acc_busy` never rises → after 256 cycles, err=3'b001 and `done` pulses once; NUM_DATA=2 with 3 SEND_DATA cycles → third word is 0 and err[1]=1.
- ctrl=6 mid-run, then SAY_IDLE → err[2]=1 and `done` pulse; `rst`=1 during a SEND_DATA phase → next cycle all outputs are 0 and state IDLE.
